mc_ctrl_fsm: RTL and testbench
==============================

// Module: mc_ctrl_fsm
// PURPOSE
//  Multi-cycle control sequencer for the RV32I core. Sequences the shared register file/immediate
//  unit, ALU, PC and memory ports through FETCH/DECODE/EXEC/MEM/WB. It uses req/ready handshakes on
//  the instruction and data ports and traps on illegal opcodes or memory timeouts.
// PARAMETERS
//  MEM_TIMEOUT  16  max wait cycles for imem/dmem ready before trap (>=1)
// PORTS
//  clk          in   1   clock
//  rst          in   1   reset, synchronous, active-low
//  opcode       in   7   inst[6:0] from IR
//  branch_taken in   1   ALU branch compare result, valid in EXEC
//  imem_ready   in   1   instruction memory ready
//  dmem_ready   in   1   data memory ready
//  imem_req     out  1   instruction fetch request
//  ir_write     out  1   load IR (pulse)
//  dmem_req     out  1   data memory request
//  dmem_we      out  1   data write enable (store)
//  reg_write    out  1   register file write strobe (pulse)
//  wb_sel       out  2   0=ALU, 1=MEM, 2=PC+4
//  pc_write     out  1   update PC (pulse)
//  pc_src       out  2   0=PC+4, 1=PC+imm (branch/JAL), 2=(rs1+imm)&~1 (JALR)
//  alu_b_imm    out  1   ALU operand B = imm32 (else rs2)
//  state        out  3   current state (debug)
//  trap_cause   out  2   0=none, 1=illegal opcode, 2=imem timeout, 3=dmem timeout
//  instret      out  32  retired instruction counter
// BEHAVIOUR
//  - States: BOOT=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6. All strobes are Moore outputs
//    of state plus opc_q.
//  - rst low at an edge: state<=BOOT, opc_q<=0, wait_cnt<=0, trap_cause<=0, instret<=0. This applies
//    in any state, including mid-handshake; reqs drop the same edge.
//  - BOOT: all outputs 0; next state FETCH unconditionally.
//  - FETCH: imem_req=1. At the edge with imem_ready=1: ir_write=1 that cycle, go to DECODE.
//  - DECODE: opc_q<=opcode. Legal opcodes go to EXEC: 0110011, 0010011, 0000011, 0100011,
//    1100011, 1101111, 1100111, 0110111, 0010111. Any other opcode goes to TRAP with cause 1.
//  - EXEC: alu_b_imm=1 for all opcodes except R (0110011) and BRANCH.
//    - LOAD/STORE -> MEM.
//    - BRANCH: pc_write=1, pc_src=branch_taken?1:0, retire -> FETCH.
//    - Others -> WB.
//  - MEM: dmem_req=1; dmem_we=1 iff STORE; request held stable until dmem_ready.
//    - On ready: LOAD -> WB.
//    - On ready: STORE -> pc_write=1, pc_src=0, retire -> FETCH.
//  - WB: reg_write=1, pc_write=1, retire -> FETCH.
//    - wb_sel=1 for LOAD, 2 for JAL/JALR, else 0.
//    - pc_src=1 for JAL, 2 for JALR, else 0.
//  - Handshake: a transfer completes at the edge where req&&ready. ready while req=0 is ignored.
//  - Timeout: wait_cnt clears on entry to FETCH/MEM and increments each non-ready cycle. When it
//    reaches MEM_TIMEOUT without ready: TRAP with cause 2 (FETCH) or 3 (MEM).
//  - TRAP: all strobes 0, trap_cause sticky; exit only via rst.
//  - Retire: instret+1 on the retiring edge, wraps 0xFFFFFFFF->0. reg_write/pc_write are never
//    asserted in BOOT/FETCH/DECODE/TRAP.
//  - Latency with zero-wait memory: BRANCH 3 cycles, ALU/JAL 4, STORE 4, LOAD 5.
// TESTING
//  1. Hold rst=0 3 cycles -> state=0, all outputs 0, instret=0. Release -> next cycle state=1,
//     imem_req=1.
//  2. ADD (0110011), imem_ready=1 -> FETCH,DECODE,EXEC,WB. In WB: reg_write=1, wb_sel=0,
//     pc_src=0. instret=1.
//  3. LOAD, dmem_ready low 3 cycles -> dmem_req high 4 cycles, dmem_we=0. Then WB with wb_sel=1.
//  4. BEQ with branch_taken=1, then 0 -> pc_write in EXEC with pc_src=1, then 0. reg_write never 1.
//  5. opcode=0000000 -> TRAP, trap_cause=1, no strobes for 20 cycles. rst=0 -> state=0.
//  6. MEM_TIMEOUT=8, STORE with dmem_ready stuck 0 -> TRAP cause 3 after 8 wait cycles. Repeat with
//     rst=0 mid-MEM -> BOOT next edge, dmem_req=0.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control sequencer for the RV32I core: steps FETCH/DECODE/EXEC/MEM/WB with
// req/ready memory handshakes, traps on illegal opcodes and memory timeouts.
module mc_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic        branch_taken,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        ir_write,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        alu_b_imm,
    output logic [2:0]  state,
    output logic [1:0]  trap_cause,
    output logic [31:0] instret
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        S_BOOT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [6:0]       opc_q, opc_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic [1:0]       cause_d;
    logic             retire;

    function automatic logic legal_op(input logic [6:0] op);
        case (op)
            OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal_op = 1'b1;
            default:                           legal_op = 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_BOOT;
            opc_q      <= '0;
            wait_q     <= '0;
            trap_cause <= '0;
            instret    <= '0;
        end else begin
            state_q    <= state_d;
            opc_q      <= opc_d;
            wait_q     <= wait_d;
            trap_cause <= cause_d;
            if (retire) begin
                instret <= instret + 32'd1;
            end
        end
    end

    // wait_d defaults to zero, so any state other than a stalled FETCH/MEM leaves it cleared
    // and each FETCH/MEM visit starts counting from zero.
    always_comb begin
        state_d   = state_q;
        opc_d     = opc_q;
        wait_d    = '0;
        cause_d   = trap_cause;
        retire    = 1'b0;
        imem_req  = 1'b0;
        ir_write  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        reg_write = 1'b0;
        wb_sel    = 2'd0;
        pc_write  = 1'b0;
        pc_src    = 2'd0;
        alu_b_imm = 1'b0;
        case (state_q)
            S_BOOT: state_d = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (wait_q == CNT_LAST) begin
                    state_d = S_TRAP;
                    cause_d = 2'd2;
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            S_DECODE: begin
                opc_d = opcode;
                if (legal_op(opcode)) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_TRAP;
                    cause_d = 2'd1;
                end
            end
            S_EXEC: begin
                alu_b_imm = (opc_q != OP_R) && (opc_q != OP_BRANCH);
                case (opc_q)
                    OP_LOAD, OP_STORE: state_d = S_MEM;
                    OP_BRANCH: begin
                        pc_write = 1'b1;
                        pc_src   = branch_taken ? 2'd1 : 2'd0;
                        retire   = 1'b1;
                        state_d  = S_FETCH;
                    end
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (opc_q == OP_STORE);
                if (dmem_ready) begin
                    if (opc_q == OP_STORE) begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_q == CNT_LAST) begin
                    state_d = S_TRAP;
                    cause_d = 2'd3;
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
                case (opc_q)
                    OP_LOAD: wb_sel = 2'd1;
                    OP_JAL: begin
                        wb_sel = 2'd2;
                        pc_src = 2'd1;
                    end
                    OP_JALR: begin
                        wb_sel = 2'd2;
                        pc_src = 2'd2;
                    end
                    default: ;
                endcase
            end
            S_TRAP: ;
            default: state_d = S_BOOT;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed, table-driven bench for mc_ctrl_fsm plus hand-written timeout and reset sequences.
module tb_mc_ctrl_fsm;

    localparam logic [6:0] OP_ADD   = 7'b0110011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_ILL   = 7'b0000000;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  opcode;
    logic        branch_taken, imem_ready, dmem_ready;
    logic        imem_req, ir_write, dmem_req, dmem_we, reg_write, pc_write, alu_b_imm;
    logic [1:0]  wb_sel, pc_src, trap_cause;
    logic [2:0]  state;
    logic [31:0] instret;

    int total = 0;
    int bad   = 0;

    mc_ctrl_fsm #(.MEM_TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
        .ir_write(ir_write), .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_write(reg_write),
        .wb_sel(wb_sel), .pc_write(pc_write), .pc_src(pc_src), .alu_b_imm(alu_b_imm),
        .state(state), .trap_cause(trap_cause), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic [6:0]  op;
        logic        bt, ir, dr;
        logic [15:0] exp;
        logic        ret;
    } vec_t;

    vec_t vq[$];

    // Packed view: {state, imem_req, ir_write, dmem_req, dmem_we, reg_write, wb_sel,
    // pc_write, pc_src, alu_b_imm, trap_cause}
    function automatic logic [15:0] o(input int st, input int imr, input int irw, input int dmr,
                                      input int dwe, input int rw, input int wb, input int pw,
                                      input int ps, input int ab, input int tc);
        return {st[2:0], imr[0], irw[0], dmr[0], dwe[0], rw[0], wb[1:0], pw[0], ps[1:0],
                ab[0], tc[1:0]};
    endfunction

    function automatic logic [15:0] act();
        return {state, imem_req, ir_write, dmem_req, dmem_we, reg_write, wb_sel, pc_write,
                pc_src, alu_b_imm, trap_cause};
    endfunction

    task automatic add(input int r, input logic [6:0] op, input int bt, input int ir,
                       input int dr, input logic [15:0] e, input int ret);
        vec_t v;
        v.r = r[0]; v.op = op; v.bt = bt[0]; v.ir = ir[0]; v.dr = dr[0];
        v.exp = e; v.ret = ret[0];
        vq.push_back(v);
    endtask

    task automatic go(input int r, input logic [6:0] op, input int bt, input int ir,
                      input int dr);
        rst = r[0]; opcode = op; branch_taken = bt[0]; imem_ready = ir[0]; dmem_ready = dr[0];
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, a, e);
        end
    endtask

    task automatic rst_seq(input logic [6:0] op);
        go(0, op, 0, 0, 0);
        clk1();
        go(1, op, 0, 0, 0);
        clk1();
    endtask

    logic [31:0] exp_ir;

    initial begin
        // reset and ADD
        add(0, OP_ADD, 0, 0, 0, o(0,0,0,0,0,0,0,0,0,0,0), 0);
        add(0, OP_ADD, 0, 0, 0, o(0,0,0,0,0,0,0,0,0,0,0), 0);
        add(0, OP_ADD, 0, 0, 0, o(0,0,0,0,0,0,0,0,0,0,0), 0);
        add(1, OP_ADD, 0, 0, 0, o(0,0,0,0,0,0,0,0,0,0,0), 0);
        add(1, OP_ADD, 0, 1, 0, o(1,1,1,0,0,0,0,0,0,0,0), 0);
        add(1, OP_ADD, 0, 0, 0, o(2,0,0,0,0,0,0,0,0,0,0), 0);
        add(1, OP_ADD, 0, 0, 0, o(3,0,0,0,0,0,0,0,0,0,0), 0);
        add(1, OP_ADD, 0, 0, 0, o(5,0,0,0,0,1,0,1,0,0,0), 1);
        // LOAD with three wait cycles
        add(1, OP_LD, 0, 1, 0, o(1,1,1,0,0,0,0,0,0,0,0), 0);
        add(1, OP_LD, 0, 0, 0, o(2,0,0,0,0,0,0,0,0,0,0), 0);
        add(1, OP_LD, 0, 0, 0, o(3,0,0,0,0,0,0,0,0,1,0), 0);
        add(1, OP_LD, 0, 0, 0, o(4,0,0,1,0,0,0,0,0,0,0), 0);
        add(1, OP_LD, 0, 0, 0, o(4,0,0,1,0,0,0,0,0,0,0), 0);
        add(1, OP_LD, 0, 0, 0, o(4,0,0,1,0,0,0,0,0,0,0), 0);
        add(1, OP_LD, 0, 0, 1, o(4,0,0,1,0,0,0,0,0,0,0), 0);
        add(1, OP_LD, 0, 0, 0, o(5,0,0,0,0,1,1,1,0,0,0), 1);
        // BEQ taken, then not taken
        add(1, OP_BR, 0, 1, 0, o(1,1,1,0,0,0,0,0,0,0,0), 0);
        add(1, OP_BR, 1, 0, 0, o(2,0,0,0,0,0,0,0,0,0,0), 0);
        add(1, OP_BR, 1, 0, 0, o(3,0,0,0,0,0,0,1,1,0,0), 1);
        add(1, OP_BR, 0, 1, 0, o(1,1,1,0,0,0,0,0,0,0,0), 0);
        add(1, OP_BR, 0, 0, 0, o(2,0,0,0,0,0,0,0,0,0,0), 0);
        add(1, OP_BR, 0, 0, 0, o(3,0,0,0,0,0,0,1,0,0,0), 1);
        // JAL, JALR
        add(1, OP_JAL, 0, 1, 0, o(1,1,1,0,0,0,0,0,0,0,0), 0);
        add(1, OP_JAL, 0, 0, 0, o(2,0,0,0,0,0,0,0,0,0,0), 0);
        add(1, OP_JAL, 0, 0, 0, o(3,0,0,0,0,0,0,0,0,1,0), 0);
        add(1, OP_JAL, 0, 0, 0, o(5,0,0,0,0,1,2,1,1,0,0), 1);
        add(1, OP_JALR, 0, 1, 0, o(1,1,1,0,0,0,0,0,0,0,0), 0);
        add(1, OP_JALR, 0, 0, 0, o(2,0,0,0,0,0,0,0,0,0,0), 0);
        add(1, OP_JALR, 0, 0, 0, o(3,0,0,0,0,0,0,0,0,1,0), 0);
        add(1, OP_JALR, 0, 0, 0, o(5,0,0,0,0,1,2,1,2,0,0), 1);
        // STORE zero-wait
        add(1, OP_ST, 0, 1, 0, o(1,1,1,0,0,0,0,0,0,0,0), 0);
        add(1, OP_ST, 0, 0, 0, o(2,0,0,0,0,0,0,0,0,0,0), 0);
        add(1, OP_ST, 0, 0, 0, o(3,0,0,0,0,0,0,0,0,1,0), 0);
        add(1, OP_ST, 0, 0, 1, o(4,0,0,1,1,0,0,1,0,0,0), 1);
        // AUIPC
        add(1, OP_AUIPC, 0, 1, 0, o(1,1,1,0,0,0,0,0,0,0,0), 0);
        add(1, OP_AUIPC, 0, 0, 0, o(2,0,0,0,0,0,0,0,0,0,0), 0);
        add(1, OP_AUIPC, 0, 0, 0, o(3,0,0,0,0,0,0,0,0,1,0), 0);
        add(1, OP_AUIPC, 0, 0, 0, o(5,0,0,0,0,1,0,1,0,0,0), 1);
        // fetch stall (dmem_ready must be ignored), then illegal opcode
        add(1, OP_ILL, 0, 0, 1, o(1,1,0,0,0,0,0,0,0,0,0), 0);
        add(1, OP_ILL, 0, 0, 1, o(1,1,0,0,0,0,0,0,0,0,0), 0);
        add(1, OP_ILL, 0, 1, 0, o(1,1,1,0,0,0,0,0,0,0,0), 0);
        add(1, OP_ILL, 0, 0, 0, o(2,0,0,0,0,0,0,0,0,0,0), 0);
        add(1, OP_ILL, 0, 1, 1, o(6,0,0,0,0,0,0,0,0,0,1), 0);

        go(0, OP_ADD, 0, 0, 0);
        clk1();
        exp_ir = 32'd0;
        for (int i = 0; i < vq.size(); i++) begin
            go(int'(vq[i].r), vq[i].op, int'(vq[i].bt), int'(vq[i].ir), int'(vq[i].dr));
            @(negedge clk);
            chk($sformatf("vec%0d_out", i), {16'h0, act()}, {16'h0, vq[i].exp});
            chk($sformatf("vec%0d_instret", i), instret, exp_ir);
            clk1();
            if (!vq[i].r)      exp_ir = 32'd0;
            else if (vq[i].ret) exp_ir = exp_ir + 32'd1;
        end

        // trap is sticky and silent regardless of inputs
        for (int i = 0; i < 20; i++) begin
            go(1, OP_ADD, i % 2, 1, 1);
            @(negedge clk);
            chk($sformatf("trap1_hold%0d", i), {16'h0, act()},
                {16'h0, o(6,0,0,0,0,0,0,0,0,0,1)});
            clk1();
        end
        chk("trap1_instret", instret, 32'd8);
        go(0, OP_ADD, 0, 0, 0);
        clk1();
        @(negedge clk);
        chk("trap1_reset", {16'h0, act()}, {16'h0, o(0,0,0,0,0,0,0,0,0,0,0)});
        chk("trap1_reset_instret", instret, 32'd0);

        // fetch timeout after 8 non-ready cycles
        rst_seq(OP_ADD);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("fto_wait%0d", i), {16'h0, act()},
                {16'h0, o(1,1,0,0,0,0,0,0,0,0,0)});
            clk1();
        end
        @(negedge clk);
        chk("fto_trap", {16'h0, act()}, {16'h0, o(6,0,0,0,0,0,0,0,0,0,2)});

        // ready on the last allowed cycle still completes the fetch
        rst_seq(OP_ADD);
        repeat (7) clk1();
        go(1, OP_ADD, 0, 1, 0);
        @(negedge clk);
        chk("fto_late_ready", {16'h0, act()}, {16'h0, o(1,1,1,0,0,0,0,0,0,0,0)});
        clk1();
        @(negedge clk);
        chk("fto_late_decode", {29'h0, state}, 32'd2);

        // store timeout
        rst_seq(OP_ST);
        go(1, OP_ST, 0, 1, 0);
        clk1();
        go(1, OP_ST, 0, 0, 0);
        clk1();
        clk1();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("sto_wait%0d", i), {16'h0, act()},
                {16'h0, o(4,0,0,1,1,0,0,0,0,0,0)});
            clk1();
        end
        @(negedge clk);
        chk("sto_trap", {16'h0, act()}, {16'h0, o(6,0,0,0,0,0,0,0,0,0,3)});
        go(1, OP_ST, 0, 1, 1);
        clk1();
        @(negedge clk);
        chk("sto_trap_sticky", {16'h0, act()}, {16'h0, o(6,0,0,0,0,0,0,0,0,0,3)});

        // reset in the middle of a data handshake
        rst_seq(OP_ST);
        go(1, OP_ST, 0, 1, 0);
        clk1();
        go(1, OP_ST, 0, 0, 0);
        clk1();
        clk1();
        clk1();
        clk1();
        @(negedge clk);
        chk("midmem_before", {16'h0, act()}, {16'h0, o(4,0,0,1,1,0,0,0,0,0,0)});
        go(0, OP_ST, 0, 0, 0);
        clk1();
        @(negedge clk);
        chk("midmem_reset", {16'h0, act()}, {16'h0, o(0,0,0,0,0,0,0,0,0,0,0)});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
